// File: rtl/smg_scan_controller_if.sv
// Load port and display outputs of the 7-segment scan controller.
// The source side uses master; the controller uses slave.
interface smg_scan_controller_if #(
    parameter int NUM_DIGITS = 4
);
    logic                      Load_Valid;
    logic [4*NUM_DIGITS-1:0]   Load_Data;
    logic [NUM_DIGITS-1:0]     Load_Dp;
    logic                      Load_Ready;
    logic [7:0]                Seg_Data;
    logic [NUM_DIGITS-1:0]     Dig_Sel;
    logic                      Frame_Done;

    modport master (
        output Load_Valid, Load_Data, Load_Dp,
        input  Load_Ready, Seg_Data, Dig_Sel, Frame_Done
    );

    modport slave (
        input  Load_Valid, Load_Data, Load_Dp,
        output Load_Ready, Seg_Data, Dig_Sel, Frame_Done
    );
endinterface

// File: rtl/smg_scan_controller.sv
// Multiplexed common-anode 7-segment scanner: double-buffered BCD frame, BLANK gap before each digit.
// Outputs registered (change on the edge entering a state); Load_Ready low while a frame is pending.
module smg_scan_controller #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int BLANK_CYC  = 500,
    parameter int LZ_BLANK   = 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    smg_scan_controller_if.slave bus
);
    localparam int MAXC = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
    localparam int CW   = $clog2(MAXC);
    localparam int IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    typedef enum logic {
        ST_BLANK,
        ST_SHOW
    } state_t;

    state_t                         state, nxt_state;
    logic [CW-1:0]                  cnt, nxt_cnt;
    logic [IW-1:0]                  idx, nxt_idx;
    logic [7:0]                     seg_q, nxt_seg;
    logic [NUM_DIGITS-1:0]          dig_q, nxt_dig;
    logic                           done_q, nxt_done;
    logic                           boundary;

    logic [NUM_DIGITS-1:0][3:0]     act_data, pend_data;
    logic [NUM_DIGITS-1:0]          act_dp, pend_dp;
    logic                           pend_full;
    logic                           accept;

    logic [NUM_DIGITS-1:0]          upper_zero;
    logic                           run_zero;
    logic [7:0]                     show_seg;
    logic [NUM_DIGITS-1:0]          show_dig;

    function automatic logic [7:0] encode(input logic [3:0] nib);
        case (nib)
            4'd0:    return 8'hC0;
            4'd1:    return 8'hF9;
            4'd2:    return 8'hA4;
            4'd3:    return 8'hB0;
            4'd4:    return 8'h99;
            4'd5:    return 8'h92;
            4'd6:    return 8'h82;
            4'd7:    return 8'hF8;
            4'd8:    return 8'h80;
            4'd9:    return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    assign accept         = bus.Load_Valid && !pend_full;
    assign bus.Load_Ready = !pend_full;
    assign bus.Seg_Data   = seg_q;
    assign bus.Dig_Sel    = dig_q;
    assign bus.Frame_Done = done_q;

    // upper_zero[i]: nibbles i..N-1 of the active frame are all zero
    always_comb begin
        upper_zero = '0;
        run_zero   = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            run_zero      = run_zero & (act_data[i] == 4'd0);
            upper_zero[i] = run_zero;
        end
    end

    always_comb begin
        show_seg = encode(act_data[idx]);
        if (LZ_BLANK != 0 && idx != '0 && upper_zero[idx])
            show_seg = 8'hFF;
        if (act_dp[idx])
            show_seg[7] = 1'b0;
        show_dig = '1;
        for (int i = 0; i < NUM_DIGITS; i++)
            show_dig[i] = (IW'(i) != idx);
    end

    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt + 1'b1;
        nxt_idx   = idx;
        nxt_seg   = seg_q;
        nxt_dig   = dig_q;
        nxt_done  = 1'b0;
        boundary  = 1'b0;
        case (state)
            ST_BLANK: begin
                if (cnt == CW'(BLANK_CYC - 1)) begin
                    nxt_state = ST_SHOW;
                    nxt_cnt   = '0;
                    nxt_seg   = show_seg;
                    nxt_dig   = show_dig;
                end
            end
            ST_SHOW: begin
                if (cnt == CW'(SCAN_DIV - 1)) begin
                    nxt_state = ST_BLANK;
                    nxt_cnt   = '0;
                    nxt_seg   = 8'hFF;
                    nxt_dig   = '1;
                    if (idx == IW'(NUM_DIGITS - 1)) begin
                        nxt_idx  = '0;
                        boundary = 1'b1;
                        nxt_done = 1'b1;
                    end else begin
                        nxt_idx = idx + 1'b1;
                    end
                end
            end
            default: begin
                nxt_state = ST_BLANK;
                nxt_cnt   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= ST_BLANK;
            cnt       <= '0;
            idx       <= '0;
            seg_q     <= 8'hFF;
            dig_q     <= '1;
            done_q    <= 1'b0;
            act_data  <= '0;
            act_dp    <= '0;
            pend_data <= '0;
            pend_dp   <= '0;
            pend_full <= 1'b0;
        end else begin
            state  <= nxt_state;
            cnt    <= nxt_cnt;
            idx    <= nxt_idx;
            seg_q  <= nxt_seg;
            dig_q  <= nxt_dig;
            done_q <= nxt_done;
            // accept implies pend_full=0, so a boundary in the same cycle has nothing to swap
            if (accept) begin
                pend_data <= bus.Load_Data;
                pend_dp   <= bus.Load_Dp;
                pend_full <= 1'b1;
            end else if (boundary && pend_full) begin
                act_data  <= pend_data;
                act_dp    <= pend_dp;
                pend_full <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_smg_scan_controller.sv
// Randomized bench for smg_scan_controller: frame-level reference model, checked every cycle.
module tb_smg_scan_controller;
    localparam int ND  = 4;
    localparam int SD  = 8;
    localparam int BC  = 2;
    localparam int SLOT = SD + BC;
    localparam int PER = ND * SLOT;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    smg_scan_controller_if #(.NUM_DIGITS(ND)) bus ();

    smg_scan_controller #(
        .NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYC(BC), .LZ_BLANK(1)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    typedef struct {
        logic [15:0] d;
        logic [3:0]  p;
    } frame_t;
    frame_t q[$];

    logic [7:0]  enc [16];
    // Reference model: clocks since reset release, displayed frame, waiting frame
    int          k;
    logic [15:0] act_d, pend_d;
    logic [3:0]  act_p, pend_p;
    bit          pend_full;

    task automatic tick();
        int         pos, dg, w;
        logic [7:0] es;
        logic [3:0] ed;
        logic [15:0] upper;
        bit         took;
        frame_t     f;
        took = 0;
        if (RST) begin
            k = 0; act_d = '0; act_p = '0; pend_full = 0;
        end else begin
            if (bus.Load_Valid && !pend_full) begin
                pend_d = bus.Load_Data; pend_p = bus.Load_Dp; pend_full = 1; took = 1;
            end else if ((k + 1) % PER == 0 && pend_full) begin
                act_d = pend_d; act_p = pend_p; pend_full = 0;
            end
            k++;
        end
        @(posedge CLK);
        @(negedge CLK);
        pos = k % PER;
        dg  = pos / SLOT;
        w   = pos % SLOT;
        if (w < BC) begin
            es = 8'hFF;
            ed = 4'hF;
        end else begin
            ed    = ~(4'(1) << dg);
            upper = act_d >> (4 * dg);
            es    = enc[upper[3:0]];
            if (dg > 0 && upper == 16'h0) es = 8'hFF;
            if (act_p[dg]) es[7] = 1'b0;
        end
        check("seg", bus.Seg_Data, es);
        check("dig", bus.Dig_Sel, ed);
        check("ready", bus.Load_Ready, !pend_full);
        check("done", bus.Frame_Done, (k > 0 && pos == 0));
        if (took) bus.Load_Valid = 1'b0;
        if (!bus.Load_Valid && !RST && q.size() > 0 && $urandom_range(0, 3) != 0) begin
            f = q.pop_front();
            bus.Load_Data  = f.d;
            bus.Load_Dp    = f.p;
            bus.Load_Valid = 1'b1;
        end
    endtask

    initial begin
        int     waited;
        bit     found;
        frame_t f;
        enc = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                8'h80, 8'h90, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        bus.Load_Valid = 1'b0;
        bus.Load_Data  = '0;
        bus.Load_Dp    = '0;
        k = 0; act_d = '0; act_p = '0; pend_d = '0; pend_p = '0; pend_full = 0;

        RST = 1'b1;
        repeat (3) tick();
        RST = 1'b0;
        repeat (PER) tick();

        q.push_back('{16'h1234, 4'b0000});
        q.push_back('{16'h0070, 4'b0000});
        q.push_back('{16'h0000, 4'b0000});
        q.push_back('{16'h00A8, 4'b0001});
        q.push_back('{16'h0500, 4'b0010});
        q.push_back('{16'h1111, 4'b0000});
        q.push_back('{16'h2222, 4'b0000});
        for (int i = 0; i < 20; i++) begin
            f.d = 16'($urandom_range(0, 65535)) >> (4 * $urandom_range(0, 3));
            f.p = 4'($urandom_range(0, 15));
            q.push_back(f);
        end

        waited = 0;
        while ((q.size() > 0 || bus.Load_Valid || pend_full) && waited < 10000) begin
            if (!RST && waited > 300 && $urandom_range(0, 399) == 0) RST = 1'b1;
            else RST = 1'b0;
            tick();
            waited++;
        end
        RST = 1'b0;
        check("drain_timeout", (waited >= 10000), 0);
        repeat (2 * PER) tick();

        // Reset during SHOW of digit 2 with a frame waiting: that frame must never appear
        q.push_back('{16'h9876, 4'b1111});
        found  = 0;
        waited = 0;
        while (!found && waited < 400) begin
            if (pend_full && ((k % PER) / SLOT) == 2 && ((k % PER) % SLOT) >= BC) found = 1;
            else begin
                tick();
                waited++;
            end
        end
        check("rst_window_found", found, 1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        repeat (2 * PER) tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
